// File: rtl/risc_pkg.sv
// Shared write-back definitions: addressing-mode and opcode codes, state encoding
// and the destination decode used by the write-back stage.
package risc_pkg;

    localparam logic [1:0] MODE_REG  = 2'b00;
    localparam logic [1:0] MODE_MEM  = 2'b01;
    localparam logic [1:0] MODE_IMM  = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;
    localparam logic [5:0] OPC_NOP   = 6'h00;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_REG_WR = 2'd1,
        WB_MEM_WR = 2'd2
    } wb_state_t;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_REG  = 2'd1,
        DEST_MEM  = 2'd2
    } wb_dest_t;

    // A NOP opcode suppresses the write whatever the mode field says.
    function automatic wb_dest_t wb_decode_dest(input logic [5:0] opcode,
                                                input logic [1:0] mode);
        if (opcode == OPC_NOP || mode == MODE_NONE) return DEST_NONE;
        if (mode == MODE_REG || mode == MODE_IMM) return DEST_REG;
        return DEST_MEM;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-cycle counter for a pending memory write; expired flags the enabled cycle
// in which the count reaches limit.
module wb_timeout_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && ((count + 1'b1) == limit);

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: commits executed results to the register file or data memory.
// Define WB_FORWARD_EN to drive the fwd_* bypass ports from the register-write strobe.
module write_back_stage
    import risc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [1:0]        in_mode,
    input  logic [3:0]        in_reg_id,
    input  logic [11:0]       in_addr,
    input  logic [DATA_W-1:0] in_result,
    output logic              wr_en_reg,
    output logic [3:0]        reg_id,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              wr_en_mem,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ack,
    output logic [15:0]       retire_count,
    output logic              err_timeout,
    output logic              fwd_valid,
    output logic [3:0]        fwd_reg_id,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int              TMO_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    wb_state_t  state;
    wb_dest_t   in_dest;
    logic       accept;
    logic       mem_done;
    logic       mem_expired;
    logic       tmo_clear;
    logic       tmo_enable;
    logic [1:0] retire_inc;

    assign in_ready   = (state != WB_MEM_WR) || mem_wr_ack;
    assign accept     = in_valid && in_ready;
    assign in_dest    = wb_decode_dest(in_opcode, in_mode);
    assign mem_done   = (state == WB_MEM_WR) && mem_wr_ack;
    assign tmo_clear  = (state != WB_MEM_WR) || mem_wr_ack;
    assign tmo_enable = (state == WB_MEM_WR) && !mem_wr_ack;

    // A memory completion and a register/no-write accept may both retire in one cycle.
    always_comb begin
        retire_inc = {1'b0, mem_done} + {1'b0, accept && (in_dest != DEST_MEM)};
    end

    wb_timeout_counter #(
        .CNT_W (TMO_W)
    ) u_mem_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .limit   (TMO_LIMIT),
        .expired (mem_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WB_IDLE;
            wr_en_reg    <= 1'b0;
            reg_id       <= '0;
            reg_wr_data  <= '0;
            wr_en_mem    <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            retire_count <= '0;
            err_timeout  <= 1'b0;
        end else begin
            wr_en_reg    <= 1'b0;
            err_timeout  <= mem_expired;
            retire_count <= retire_count + 16'(retire_inc);
            if (mem_done || mem_expired) begin
                wr_en_mem <= 1'b0;
            end
            if (accept) begin
                case (in_dest)
                    DEST_REG: begin
                        state       <= WB_REG_WR;
                        wr_en_reg   <= 1'b1;
                        reg_id      <= in_reg_id;
                        reg_wr_data <= in_result;
                    end
                    DEST_MEM: begin
                        state       <= WB_MEM_WR;
                        wr_en_mem   <= 1'b1;
                        mem_addr    <= {4'b0000, in_addr};
                        mem_wr_data <= in_result;
                    end
                    default: state <= WB_IDLE;
                endcase
            end else if (state != WB_MEM_WR || mem_done || mem_expired) begin
                state <= WB_IDLE;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid  = wr_en_reg;
    assign fwd_reg_id = reg_id;
    assign fwd_data   = reg_wr_data;
`else
    assign fwd_valid  = 1'b0;
    assign fwd_reg_id = '0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed vector table, multi-cycle corner sequences
// and a randomized run against a transaction-level model of the commit rules.
module tb_write_back_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [1:0]  in_mode;
    logic [3:0]  in_reg_id;
    logic [11:0] in_addr;
    logic [15:0] in_result;
    logic        wr_en_reg;
    logic [3:0]  reg_id;
    logic [15:0] reg_wr_data;
    logic        wr_en_mem;
    logic [15:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_ack;
    logic [15:0] retire_count;
    logic        err_timeout;
    logic        fwd_valid;
    logic [3:0]  fwd_reg_id;
    logic [15:0] fwd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    write_back_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_mode      (in_mode),
        .in_reg_id    (in_reg_id),
        .in_addr      (in_addr),
        .in_result    (in_result),
        .wr_en_reg    (wr_en_reg),
        .reg_id       (reg_id),
        .reg_wr_data  (reg_wr_data),
        .wr_en_mem    (wr_en_mem),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ack   (mem_wr_ack),
        .retire_count (retire_count),
        .err_timeout  (err_timeout),
        .fwd_valid    (fwd_valid),
        .fwd_reg_id   (fwd_reg_id),
        .fwd_data     (fwd_data)
    );

    typedef struct {
        logic [5:0]  opc;
        logic [1:0]  mode;
        logic [3:0]  rid;
        logic [11:0] addr;
        logic [15:0] res;
        logic        exp_reg;
        logic        exp_mem;
        logic [15:0] exp_addr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_fwd(input string tag, input logic ev, input logic [3:0] eid,
                             input logic [15:0] ed);
`ifdef WB_FORWARD_EN
        check({tag, "_fwd_valid"}, fwd_valid, ev);
        if (ev) begin
            check({tag, "_fwd_reg_id"}, fwd_reg_id, eid);
            check({tag, "_fwd_data"}, fwd_data, ed);
        end
`else
        check({tag, "_fwd_valid_off"}, fwd_valid, 0);
        check({tag, "_fwd_reg_id_off"}, fwd_reg_id, 0);
        check({tag, "_fwd_data_off"}, fwd_data, 0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] opc, input logic [1:0] mode,
                         input logic [3:0] rid, input logic [11:0] addr, input logic [15:0] res);
        in_valid  = v;
        in_opcode = opc;
        in_mode   = mode;
        in_reg_id = rid;
        in_addr   = addr;
        in_result = res;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        mem_wr_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt[7];
        logic [15:0] exp_rc;
        int          hi;
        int          pulses;
        int          err_at;

        vt[0] = '{6'h01, 2'b00, 4'h3, 12'h0A0, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        vt[1] = '{6'h05, 2'b10, 4'h7, 12'h111, 16'h00FF, 1'b1, 1'b0, 16'h0000};
        vt[2] = '{6'h02, 2'b01, 4'h1, 12'hFFF, 16'h5555, 1'b0, 1'b1, 16'h0FFF};
        vt[3] = '{6'h00, 2'b00, 4'h4, 12'h000, 16'hAAAA, 1'b0, 1'b0, 16'h0000};
        vt[4] = '{6'h3F, 2'b11, 4'h9, 12'h222, 16'h1357, 1'b0, 1'b0, 16'h0000};
        vt[5] = '{6'h00, 2'b01, 4'h2, 12'h333, 16'h2468, 1'b0, 1'b0, 16'h0000};
        vt[6] = '{6'h3F, 2'b01, 4'hF, 12'h123, 16'hC0DE, 1'b0, 1'b1, 16'h0123};

        drive(1'b0, 6'h00, 2'b00, 4'h0, 12'h000, 16'h0000);
        do_reset();

        // reset state
        check("rst_wr_en_reg", wr_en_reg, 0);
        check("rst_reg_id", reg_id, 0);
        check("rst_reg_wr_data", reg_wr_data, 0);
        check("rst_wr_en_mem", wr_en_mem, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
        check("rst_retire", retire_count, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_in_ready", in_ready, 1);
        check_fwd("rst", 1'b0, 4'h0, 16'h0000);

        // register write, one-cycle strobe in N+1
        drive(1'b1, 6'h01, 2'b00, 4'h3, 12'h000, 16'hBEEF);
        tick();
        in_valid = 1'b0;
        check("reg_wr_en", wr_en_reg, 1);
        check("reg_id", reg_id, 4'h3);
        check("reg_data", reg_wr_data, 16'hBEEF);
        check("reg_retire", retire_count, 1);
        check_fwd("reg", 1'b1, 4'h3, 16'hBEEF);
        tick();
        check("reg_strobe_end", wr_en_reg, 0);
        check_fwd("reg_end", 1'b0, 4'h0, 16'h0000);
        exp_rc = 16'd1;

        // vector table: one transaction each, memory ones acked immediately
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vt[i].opc, vt[i].mode, vt[i].rid, vt[i].addr, vt[i].res);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_wr_en_reg", i), wr_en_reg, vt[i].exp_reg);
            check($sformatf("vec%0d_wr_en_mem", i), wr_en_mem, vt[i].exp_mem);
            if (vt[i].exp_reg) begin
                check($sformatf("vec%0d_reg_id", i), reg_id, vt[i].rid);
                check($sformatf("vec%0d_reg_data", i), reg_wr_data, vt[i].res);
            end
            if (vt[i].exp_mem) begin
                check($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].exp_addr);
                check($sformatf("vec%0d_mem_data", i), mem_wr_data, vt[i].res);
            end
            check_fwd($sformatf("vec%0d", i), vt[i].exp_reg, vt[i].rid, vt[i].res);
            mem_wr_ack = vt[i].exp_mem;
            tick();
            mem_wr_ack = 1'b0;
            exp_rc = exp_rc + 16'd1;
            check($sformatf("vec%0d_retire", i), retire_count, exp_rc);
            check($sformatf("vec%0d_idle_reg", i), wr_en_reg, 0);
            check($sformatf("vec%0d_idle_mem", i), wr_en_mem, 0);
        end

        // memory write, ack held low three cycles then high
        drive(1'b1, 6'h01, 2'b01, 4'h0, 12'h0A5, 16'h1234);
        tick();
        in_valid = 1'b0;
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            mem_wr_ack = (k == 3);
            #1;
            if (wr_en_mem) begin
                hi++;
                check($sformatf("mem_addr_c%0d", k), mem_addr, 16'h00A5);
                check($sformatf("mem_data_c%0d", k), mem_wr_data, 16'h1234);
                check($sformatf("mem_ready_c%0d", k), in_ready, (k == 3));
            end
            if (k < 3) check($sformatf("mem_retire_wait_c%0d", k), retire_count, exp_rc);
            tick();
            mem_wr_ack = 1'b0;
        end
        exp_rc = exp_rc + 16'd1;
        check("mem_high_cycles", hi, 4);
        check("mem_retire", retire_count, exp_rc);

        // timeout: ack never comes
        drive(1'b1, 6'h01, 2'b01, 4'h0, 12'h0C3, 16'h9999);
        tick();
        in_valid = 1'b0;
        hi = 0;
        pulses = 0;
        err_at = -1;
        for (int k = 0; k < 25; k++) begin
            if (wr_en_mem) hi++;
            if (err_timeout) begin
                pulses++;
                err_at = k;
            end
            tick();
        end
        check("tmo_high_cycles", hi, 15);
        check("tmo_err_pulses", pulses, 1);
        check("tmo_err_cycle", err_at, 15);
        check("tmo_retire", retire_count, exp_rc);
        check("tmo_in_ready", in_ready, 1);

        // ack in the cycle the limit is reached wins
        drive(1'b1, 6'h01, 2'b01, 4'h0, 12'h0D4, 16'h7777);
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        mem_wr_ack = 1'b1;
        #1;
        check("limit_ack_wr_en_mem", wr_en_mem, 1);
        tick();
        mem_wr_ack = 1'b0;
        exp_rc = exp_rc + 16'd1;
        check("limit_ack_err", err_timeout, 0);
        check("limit_ack_wr_en_mem_end", wr_en_mem, 0);
        check("limit_ack_retire", retire_count, exp_rc);

        // reset in the middle of a memory write
        drive(1'b1, 6'h01, 2'b01, 4'h0, 12'h055, 16'h4321);
        tick();
        in_valid = 1'b0;
        check("rstmid_wr_en_mem_before", wr_en_mem, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_wr_en_mem", wr_en_mem, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_retire", retire_count, 0);
        tick();
        check("rstmid_wr_en_mem_later", wr_en_mem, 0);
        check("rstmid_retire_later", retire_count, 0);

        // back-to-back mode-10 results
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 6'h04, 2'b10, 4'(k + 5), 12'h000, 16'(16'hA000 + k));
            if (k > 0) begin
                check($sformatf("b2b_strobe%0d", k - 1), wr_en_reg, 1);
                check($sformatf("b2b_id%0d", k - 1), reg_id, 4'(k + 4));
                check($sformatf("b2b_data%0d", k - 1), reg_wr_data, 16'(16'hA000 + k - 1));
            end
            #1;
            check($sformatf("b2b_ready%0d", k), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_strobe2", wr_en_reg, 1);
        check("b2b_id2", reg_id, 4'h7);
        check("b2b_data2", reg_wr_data, 16'hA002);
        tick();
        check("b2b_strobe_end", wr_en_reg, 0);
        check("b2b_retire", retire_count, 3);

        // randomized run against the commit-rule model
        do_reset();
        begin
            logic        pend;
            logic [15:0] paddr;
            logic [15:0] pdata;
            logic        erv;
            logic [3:0]  erid;
            logic [15:0] erdata;
            logic [15:0] ecnt;
            logic        rdy;
            int          wcnt;
            pend   = 1'b0;
            paddr  = '0;
            pdata  = '0;
            erv    = 1'b0;
            erid   = '0;
            erdata = '0;
            ecnt   = '0;
            wcnt   = 0;
            for (int c = 0; c < 400; c++) begin
                check("rnd_retire", retire_count, ecnt);
                check("rnd_wr_en_reg", wr_en_reg, erv);
                if (erv) begin
                    check("rnd_reg_id", reg_id, erid);
                    check("rnd_reg_data", reg_wr_data, erdata);
                end
                check_fwd("rnd", erv, erid, erdata);
                check("rnd_wr_en_mem", wr_en_mem, pend);
                if (pend) begin
                    check("rnd_mem_addr", mem_addr, paddr);
                    check("rnd_mem_data", mem_wr_data, pdata);
                end
                check("rnd_err_timeout", err_timeout, 0);
                erv = 1'b0;
                if (pend) begin
                    wcnt++;
                    mem_wr_ack = (wcnt >= 6) || ($urandom_range(0, 2) == 0);
                end else begin
                    mem_wr_ack = 1'b0;
                end
                drive(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(1, 63)),
                      2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      12'($urandom_range(0, 4095)), 16'($urandom_range(0, 65535)));
                #1;
                rdy = !pend || mem_wr_ack;
                check("rnd_in_ready", in_ready, rdy);
                if (pend && mem_wr_ack) begin
                    pend = 1'b0;
                    ecnt = ecnt + 16'd1;
                    wcnt = 0;
                end
                if (in_valid && rdy) begin
                    if (in_opcode == 6'h00 || in_mode == 2'b11) begin
                        ecnt = ecnt + 16'd1;
                    end else if (in_mode == 2'b01) begin
                        pend  = 1'b1;
                        paddr = {4'h0, in_addr};
                        pdata = in_result;
                        wcnt  = 0;
                    end else begin
                        erv    = 1'b1;
                        erid   = in_reg_id;
                        erdata = in_result;
                        ecnt   = ecnt + 16'd1;
                    end
                end
                tick();
            end
            in_valid   = 1'b0;
            mem_wr_ack = 1'b0;
        end

        // retire counter wrap through a stream of NOPs
        do_reset();
        drive(1'b1, 6'h00, 2'b00, 4'h1, 12'h000, 16'h0000);
        repeat (65535) tick();
        in_valid = 1'b0;
        check("wrap_preload", retire_count, 16'hFFFF);
        check("wrap_nop_no_reg", wr_en_reg, 0);
        check("wrap_nop_no_mem", wr_en_mem, 0);
        check_fwd("wrap", 1'b0, 4'h0, 16'h0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("wrap_zero", retire_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
